// File: rtl/pipe_share_ctrl.sv
// pipe_share_ctrl
// Shares one fixed-latency arithmetic pipeline between two requesters.
// - Round-robin arbitration with valid/ready handshakes. At most one operand
//   is issued per cycle.
// - A {valid, id} tag pipe runs beside the datapath, so each result returns
//   to the requester that issued it.
// - A flush sequencer stops issue, waits for in-flight work to drain, then
//   pulses flush_done.
//
// Optional build macro:
//   PIPE_SHARE_PRIO_EN - requester 0 gets strict priority instead of
//                        round-robin.
//
// Ports:
//   clock, reset                - posedge clock, synchronous active-low reset
//   req0_valid/data/ready       - requester 0 operand handshake
//   req1_valid/data/ready       - requester 1 operand handshake
//   pipe_in_data/pipe_in_valid  - operand to the pipeline (combinational from grant)
//   pipe_out_data               - pipeline result, LAT cycles after issue
//   rsp0_valid/rsp1_valid       - single-cycle result strobes, per requester
//   rsp_data                    - registered copy of pipe_out_data
//   flush_req/flush_done        - drain request / one-cycle completion pulse
//   busy                        - work in flight or sequencer not in RUN
module pipe_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int LAT   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] pipe_in_data,
  output logic             pipe_in_valid,
  input  logic [WIDTH-1:0] pipe_out_data,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             busy
);

  localparam int CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  state_e            state_q, state_d;
  tag_t [LAT-1:0]    tag_q, tag_d;
  logic              last_grant_q, last_grant_d;
  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic grant_en;
  logic gnt_valid;
  logic gnt_id;
  logic retire;

  // ---------------------------------------------------------------- FSM
  // NOTE: reset is sampled on the clock edge only (synchronous). Every
  // sequential block tests it first, and nothing lists it in a sensitivity
  // list.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (in_flight_q == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Grants are gated by reset, so no handshake completes while reset is
  // held. A flush request in RUN also suppresses the grant that same cycle.
  always_comb begin
    grant_en   = reset && (state_q == RUN) && !flush_req;
    flush_done = (state_q == DONE);
  end

  // ---------------------------------------------------------- arbitration
  // NOTE: every signal assigned in an always_comb gets a default at the
  // top. Without it, a missed branch infers a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (grant_en) begin
`ifdef PIPE_SHARE_PRIO_EN
      if (req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
`else
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_grant_q;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    req0_ready    = gnt_valid && !gnt_id;
    req1_ready    = gnt_valid &&  gnt_id;
    pipe_in_valid = gnt_valid;
    pipe_in_data  = '0;
    if (gnt_valid) pipe_in_data = gnt_id ? req1_data : req0_data;
  end

  // ------------------------------------------- tag pipe and bookkeeping
  // Leaving the last tag stage is the retire event. The pipeline result is
  // captured on that edge and presented, with its strobe, on the following
  // cycle.
  assign retire = tag_q[LAT-1].valid;

  always_comb begin
    tag_d[0]       = '{valid: gnt_valid, id: gnt_id};
    for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];

    last_grant_d   = gnt_valid ? gnt_id : last_grant_q;

    in_flight_d    = in_flight_q;
    if (gnt_valid && !retire)      in_flight_d = in_flight_q + CW'(1);
    else if (!gnt_valid && retire) in_flight_d = in_flight_q - CW'(1);

    rsp0_valid_d   = retire && !tag_q[LAT-1].id;
    rsp1_valid_d   = retire &&  tag_q[LAT-1].id;
    rsp_data_d     = retire ? pipe_out_data : rsp_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples the pre-edge value, whatever order the statements are in.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_q        <= '0;
      last_grant_q <= 1'b1;
      in_flight_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
      in_flight_q  <= in_flight_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (in_flight_q != '0) || (state_q != RUN);

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Testbench for pipe_share_ctrl.
// Inputs are driven on the falling edge and outputs are compared 1 time
// unit later. Expectations come from a cycle-indexed reference model:
// - Each grant schedules a response for its requester LAT+1 cycles later.
//   The response carries the pipeline output driven in the cycle before it.
// - The flush sequencer is modelled as run / draining / done phases.
module tb_pipe_share_ctrl;
  localparam int WIDTH = 32;
  localparam int LAT   = 3;
  localparam int HSZ   = 2048;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid, flush_req;
  logic [WIDTH-1:0] req0_data, req1_data, pipe_out_data;
  logic             req0_ready, req1_ready, pipe_in_valid;
  logic [WIDTH-1:0] pipe_in_data, rsp_data;
  logic             rsp0_valid, rsp1_valid, flush_done, busy;

  pipe_share_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pipe_in_data(pipe_in_data), .pipe_in_valid(pipe_in_valid),
    .pipe_out_data(pipe_out_data),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // Reference model state
  typedef enum int {M_RUN, M_DRAIN, M_DONE} phase_e;
  phase_e           m_phase = M_RUN;
  bit               m_last  = 1'b1;   // requester that won the latest grant
  int               issued[$];        // cycle numbers of live issues
  bit               rsp_v  [HSZ];
  bit               rsp_id [HSZ];
  logic [WIDTH-1:0] pout   [HSZ];
  bit               prev_rst = 1'b0;  // reset asserted in the previous cycle

  task automatic step(input bit rst, input bit v0, input logic [WIDTH-1:0] d0,
                      input bit v1, input logic [WIDTH-1:0] d1, input bit fl);
    bit               g_v, g_id;
    int               infl;
    logic [WIDTH-1:0] exp_in;
    @(negedge clock);
    reset      = rst;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    flush_req  = fl;
    pipe_out_data = $urandom;
    pout[cyc]  = pipe_out_data;
    #1;

    // Work counted in flight: issued, not yet past its last tag stage.
    while (issued.size() > 0 && issued[0] + LAT < cyc) void'(issued.pop_front());
    infl = issued.size();

    g_v = 1'b0; g_id = 1'b0;
    if (rst && m_phase == M_RUN && !fl && (v0 || v1)) begin
      g_v = 1'b1;
`ifdef PIPE_SHARE_PRIO_EN
      g_id = !v0;
`else
      g_id = (v0 && v1) ? !m_last : !v0;
`endif
    end
    exp_in = g_v ? (g_id ? d1 : d0) : '0;

    check("req0_ready",    WIDTH'(req0_ready),    WIDTH'(g_v && !g_id));
    check("req1_ready",    WIDTH'(req1_ready),    WIDTH'(g_v && g_id));
    check("pipe_in_valid", WIDTH'(pipe_in_valid), WIDTH'(g_v));
    check("pipe_in_data",  pipe_in_data,          exp_in);
    check("rsp0_valid",    WIDTH'(rsp0_valid),    WIDTH'(rsp_v[cyc] && !rsp_id[cyc]));
    check("rsp1_valid",    WIDTH'(rsp1_valid),    WIDTH'(rsp_v[cyc] && rsp_id[cyc]));
    if (rsp_v[cyc])    check("rsp_data",       rsp_data, pout[cyc-1]);
    else if (prev_rst) check("rsp_data_reset", rsp_data, '0);
    check("flush_done",    WIDTH'(flush_done),    WIDTH'(m_phase == M_DONE));
    check("busy",          WIDTH'(busy),          WIDTH'(infl != 0 || m_phase != M_RUN));

    // Effect of the coming clock edge
    if (!rst) begin
      m_phase = M_RUN;
      m_last  = 1'b1;
      issued.delete();
      for (int k = cyc + 1; k < HSZ; k++) rsp_v[k] = 1'b0;
    end else begin
      if (g_v) begin
        issued.push_back(cyc);
        rsp_v[cyc+LAT+1]  = 1'b1;
        rsp_id[cyc+LAT+1] = g_id;
        m_last = g_id;
      end
      case (m_phase)
        M_RUN:   if (fl) m_phase = M_DRAIN;
        M_DRAIN: if (infl == 0) m_phase = M_DONE;
        default: m_phase = M_RUN;
      endcase
    end
    prev_rst = !rst;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0, 0);
  endtask

  initial begin
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; flush_req = 1'b0;
    req0_data = '0; req1_data = '0; pipe_out_data = '0;

    // Reset held with both requesters valid, then a tie goes to requester 0
    repeat (2) step(0, 1, $urandom, 1, $urandom, 0);
    step(1, 1, 32'h10, 1, $urandom, 0);
    idle(LAT + 2);

    // Continuous contention: alternating grants and responses
    for (int i = 0; i < 6; i++) step(1, 1, $urandom, 1, $urandom, 0);
    idle(LAT + 2);

    // Three in flight, then a flush pulse while requests keep coming
    for (int i = 0; i < 3; i++) step(1, 1, $urandom, 0, '0, 0);
    step(1, 1, $urandom, 1, $urandom, 1);
    for (int i = 0; i < LAT + 5; i++) step(1, 1, $urandom, 1, $urandom, 0);
    idle(LAT + 2);

    // Flush with nothing in flight
    step(1, 0, '0, 0, '0, 1);
    idle(4);

    // Flush beats a same-cycle request, then reset lands during the drain
    step(1, 1, $urandom, 0, '0, 0);
    step(1, 1, $urandom, 0, '0, 1);
    step(1, 1, $urandom, 1, $urandom, 0);
    step(0, 1, $urandom, 1, $urandom, 0);
    idle(LAT + 4);

    // Randomised traffic with occasional flushes and resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) != 0,
           1'($urandom_range(0, 99) < 70), $urandom,
           1'($urandom_range(0, 99) < 60), $urandom,
           $urandom_range(0, 99) < 4);
    idle(LAT + 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_share_ctrl.md
Name: pipe_share_ctrl

Overview:
Shares one fixed-latency arithmetic pipeline (dataIn -> dataOut, LAT cycles) between two requesters. Arbitrates round-robin with valid/ready handshakes and issues at most one operand per cycle. Carries a valid/tag shift register alongside the pipeline so each result returns to the requester that issued it. Includes a flush sequencer that stops issue and drains in-flight work before signalling completion.

Parameters:
WIDTH, 32, data width of operands and results
LAT, 3, pipeline latency in cycles from pipe_in_data sampled to pipe_out_data valid (1..8)

Ports:
clock  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-low reset
req0_valid  in  1  requester 0 has operand
req0_data  in  WIDTH  requester 0 operand
req0_ready  out  1  requester 0 operand accepted this cycle
req1_valid  in  1  requester 1 has operand
req1_data  in  WIDTH  requester 1 operand
req1_ready  out  1  requester 1 operand accepted this cycle
pipe_in_data  out  WIDTH  operand driven to pipeline dataIn
pipe_in_valid  out  1  pipe_in_data carries an issued operand
pipe_out_data  in  WIDTH  pipeline dataOut
rsp0_valid  out  1  result for requester 0 (single-cycle, no backpressure)
rsp1_valid  out  1  result for requester 1
rsp_data  out  WIDTH  registered copy of pipe_out_data
flush_req  in  1  request drain
flush_done  out  1  one-cycle pulse: drain complete
busy  out  1  in_flight != 0 or state != RUN

Behaviour:
- Reset (reset=0 at posedge): state=RUN, last_grant=1 (so req0 wins first tie), tag pipe cleared, in_flight=0; all outputs 0 on the following cycle (ready, rsp*_valid, pipe_in_valid, flush_done, busy, rsp_data, pipe_in_data).
- Reset mid-operation discards all in-flight tags; no rsp*_valid for operands issued before reset.
- Grant (combinational, RUN only, flush_req=0): one valid -> that one; both valid -> the one != last_grant. reqN_ready=grant; last_grant updates on each grant.
- Issue: pipe_in_data/pipe_in_valid = muxed operand, combinational from grant; zero when no grant.
- Tag pipe: LAT-deep shift of {valid, id}; stage 0 loaded on issue. When the stage LAT-1 entry is valid, the next cycle drives rspN_valid=1 (N=id) and rsp_data=pipe_out_data sampled that edge; total issue-to-rsp = LAT+1 cycles.
- in_flight: 0..LAT+1 counter; +1 on issue, -1 on rsp; simultaneous both -> unchanged.
- FSM:
  RUN: grants enabled; flush_req=1 -> DRAIN (no grant that cycle, flush beats request).
  DRAIN: no grants; flush_req ignored; in_flight==0 -> DONE.
  DONE: flush_done=1 for exactly one cycle; -> RUN.
- flush_req in RUN with in_flight already 0: RUN -> DRAIN -> DONE, pulse 2 cycles after request.
- Back-to-back issue every cycle allowed; throughput 1/cycle total.

Optional Feature:
PIPE_SHARE_PRIO_EN: when defined, requester 0 has strict priority (req1 granted only when req0_valid=0); last_grant is unused. When undefined, round-robin as above.

Test Plan:
- Reset held 2 cycles with both valids high -> all outputs 0, no ready; first cycle after release both valid -> req0_ready=1.
- LAT=3, req0 issues 0x10 at cycle t, pipe_out_data=0xAB at t+3 -> rsp0_valid=1, rsp_data=0xAB at t+4, rsp1_valid=0.
- Both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses alternate rsp0/rsp1 LAT+1 cycles later.
- 3 issues in flight, flush_req pulsed -> no ready until flush_done; flush_done pulses 1 cycle after final rsp; busy=0 after.
- flush_req and req0_valid same cycle in RUN -> req0_ready=0; reset asserted during DRAIN -> no further rsp, state RUN, flush_done never pulses.
- PIPE_SHARE_PRIO_EN defined, both valid 4 cycles -> req0_ready=1 every cycle, req1_ready=0.
